// File: rtl/tx_link_pkg.sv
// tx_link_pkg: shared link constants (flit width, router port directions).
package tx_link_pkg;
  localparam int FLIT_SIZE = 8;
  typedef enum logic [2:0] {DIR_NORTH, DIR_EAST, DIR_SOUTH, DIR_WEST, DIR_LOCAL} dir_e;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous control bit.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q <= 1'b0;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/tx_link.sv
// tx_link: 2-entry flit FIFO drained over a 4-phase req/ack handshake to a neighbour router.
module tx_link
  import tx_link_pkg::*;
#(
  parameter int SIZE = FLIT_SIZE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ena,
  input  logic [SIZE-1:0] item_in,
  output logic            busy,
  output logic            req,
  output logic [SIZE-1:0] data_out,
  input  logic            ack
);
  typedef enum logic [1:0] {IDLE, REQ, REL} state_e;
  state_e state, state_n;
  logic [SIZE-1:0] mem [2];
  logic head, tail, wr, pop, load, ack_s;
  logic [1:0] count;
  sync2 u_sync (.clk(clk), .reset_n(reset_n), .d(ack), .q(ack_s));
  assign busy = count == 2'd2;
  assign wr = ena && !busy;
  always_comb begin
    load = state == IDLE && count != 2'd0;
    pop = state == REQ && ack_s;
    state_n = load ? REQ : pop ? REL : (state == REL && !ack_s) ? IDLE : state;
  end
  // req is registered so the neighbour never sees a decode glitch on state changes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      req <= 1'b0;
      data_out <= '0;
      count <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      state <= state_n;
      req <= state_n == REQ;
      if (load) data_out <= mem[head];
      if (wr) tail <= ~tail;
      if (pop) head <= ~head;
      count <= count + {1'b0, wr} - {1'b0, pop};
    end
  end
  always_ff @(posedge clk) if (wr) mem[tail] <= item_in;
endmodule

// File: tb/tb_tx_link.sv
// tb_tx_link: directed and random-stress checks of the tx_link FIFO and 4-phase handshake.
module tb_tx_link;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ena = 1'b0;
  logic [7:0] item_in = 8'h00;
  logic ack = 1'b0;
  logic busy, req;
  logic [7:0] data_out;
  int vectors = 0;
  int miscompares = 0;

  tx_link #(.SIZE(8)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .item_in(item_in),
    .busy(busy), .req(req), .data_out(data_out), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // full handshake for one flit: wait req, check data, ack, check fall latency, release
  task automatic xfer(input logic [7:0] exp);
    int n;
    n = 0;
    while (!req && n < 20) begin step(); n++; end
    chk("xfer_req_up", {31'd0, req}, 32'd1);
    chk("xfer_data", {24'd0, data_out}, {24'd0, exp});
    ack = 1'b1;
    n = 0;
    while (req && n < 20) begin step(); n++; end
    chk("xfer_req_fall_cycles", n, 32'd3);
    ack = 1'b0;
    repeat (3) step();
    chk("xfer_gap_req_low", {31'd0, req}, 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] held;
    logic prev_req, armed, phase;
    int delay, sent, got, cyc;
    // reset
    repeat (3) step();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_req", {31'd0, req}, 32'd0);
    end
    // single flit
    ena = 1'b1; item_in = 8'h3A;
    step();
    ena = 1'b0;
    chk("single_no_req_yet", {31'd0, req}, 32'd0);
    step();
    chk("single_req", {31'd0, req}, 32'd1);
    chk("single_data", {24'd0, data_out}, 32'h3A);
    xfer(8'h3A);
    chk("single_busy", {31'd0, busy}, 32'd0);
    // fill: third write must be dropped
    ena = 1'b1; item_in = 8'h01;
    step();
    item_in = 8'h02;
    step();
    chk("fill_busy", {31'd0, busy}, 32'd1);
    chk("fill_req", {31'd0, req}, 32'd1);
    chk("fill_data", {24'd0, data_out}, 32'h01);
    item_in = 8'h03;
    step();
    ena = 1'b0;
    chk("fill_busy_hold", {31'd0, busy}, 32'd1);
    chk("fill_data_hold", {24'd0, data_out}, 32'h01);
    xfer(8'h01);
    xfer(8'h02);
    chk("fill_empty", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fill_no_third", {31'd0, req}, 32'd0);
    end
    // write and pop on the same edge
    ena = 1'b1; item_in = 8'h11;
    step();
    ena = 1'b0;
    step();
    chk("wp_req", {31'd0, req}, 32'd1);
    ack = 1'b1;
    step();
    step();
    ena = 1'b1; item_in = 8'h22;
    step();
    ena = 1'b0;
    chk("wp_req_fall", {31'd0, req}, 32'd0);
    chk("wp_busy", {31'd0, busy}, 32'd0);
    ack = 1'b0;
    repeat (3) step();
    xfer(8'h22);
    chk("wp_empty", {31'd0, busy}, 32'd0);
    // full FIFO, ena held across the pop
    ena = 1'b1; item_in = 8'h01;
    step();
    item_in = 8'h02;
    step();
    item_in = 8'h04;
    chk("sim_busy", {31'd0, busy}, 32'd1);
    ack = 1'b1;
    step();
    chk("sim_busy_still", {31'd0, busy}, 32'd1);
    step();
    step();
    chk("sim_pop_req", {31'd0, req}, 32'd0);
    chk("sim_pop_busy", {31'd0, busy}, 32'd0);
    chk("sim_data_held", {24'd0, data_out}, 32'h01);
    step();
    ena = 1'b0;
    chk("sim_refill_busy", {31'd0, busy}, 32'd1);
    ack = 1'b0;
    repeat (3) step();
    xfer(8'h02);
    xfer(8'h04);
    chk("sim_empty", {31'd0, busy}, 32'd0);
    // reset in the middle of a handshake
    ena = 1'b1; item_in = 8'h55;
    step();
    ena = 1'b0;
    step();
    chk("mid_req", {31'd0, req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_async_req", {31'd0, req}, 32'd0);
    chk("mid_async_data", {24'd0, data_out}, 32'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_no_req", {31'd0, req}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd0);
    end
    // random stress with scoreboard
    sent = 0; got = 0; cyc = 0; phase = 1'b0; armed = 1'b0; prev_req = 1'b0; delay = 0; held = 8'h00;
    while (got < 1000 && cyc < 60000) begin
      if (req && !prev_req) begin
        if (q.size() > 0) chk("rnd_order", {24'd0, data_out}, {24'd0, q.pop_front()});
        else chk("rnd_spurious_req", {31'd0, req}, 32'd0);
        held = data_out;
      end else if (req) begin
        chk("rnd_stable", {24'd0, data_out}, {24'd0, held});
      end
      prev_req = req;
      if (!phase && req) begin
        if (!armed) begin delay = $urandom_range(0, 7); armed = 1'b1; end
        if (delay == 0) begin ack = 1'b1; phase = 1'b1; armed = 1'b0; end
        else delay--;
      end else if (phase && !req) begin
        ack = 1'b0; phase = 1'b0; got++;
      end
      ena = sent < 1000 && $urandom_range(0, 1) == 1;
      item_in = 8'($urandom);
      if (ena && !busy) begin q.push_back(item_in); sent++; end
      step();
      cyc++;
    end
    ena = 1'b0;
    chk("rnd_delivered", got, 32'd1000);
    chk("rnd_queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tx_link.md
TX_LINK -- requirements
Module: tx_link

Interface
REQ-001 Parameter: SIZE, default `SIZE from the shared constants include, flit width in bits.
REQ-002 Port: clk  input  1  single clock; all state is updated on the rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: ena  input  1  write strobe from the upstream tx logic for this direction.
REQ-005 Port: item_in  input  SIZE  flit, sampled when ena=1.
REQ-006 Port: busy  output  1  back-pressure to the upstream ena generation.
REQ-007 Port: req  output  1  4-phase request to the neighbour router.
REQ-008 Port: data_out  output  SIZE  flit to the neighbour; stable whenever req=1.
REQ-009 Port: ack  input  1  4-phase acknowledge from the neighbour; asynchronous to clk.

Function
REQ-010 The block SHALL hold a 2-entry FIFO with head pointer, tail pointer and 2-bit count (0..2), both pointers wrapping 1->0.
REQ-011 busy SHALL equal (count==2), decoded combinationally from registered count only, with no path from ena.
REQ-012 ena=1 with busy=0 SHALL write item_in at tail on that edge: tail+1, count+1.
REQ-013 ena=1 with busy=1 SHALL be ignored: no write, no state change.
REQ-014 ack SHALL pass through a 2-flop synchronizer; ack_s denotes its output, 2 cycles of latency.
REQ-015 Link FSM states: IDLE, REQ, REL.
REQ-016 In IDLE with count>0 at an edge: next state REQ, req<=1, data_out<=entry[head].
REQ-017 In IDLE with count==0: remain in IDLE, req=0, data_out holds its last value.
REQ-018 In REQ with ack_s=1: req<=0, pop head (head+1, count-1), next state REL.
REQ-019 In REQ with ack_s=0: hold req=1 and data_out unchanged, with no timeout.
REQ-020 In REL with ack_s=0: next state IDLE. With ack_s=1: stay in REL.
REQ-021 A write and a pop on the same edge SHALL leave count unchanged and advance both pointers.
REQ-022 Minimum latency from accepting a write into an empty FIFO in IDLE to req=1 SHALL be 1 cycle (req rises on the next edge).
REQ-023 Back-to-back flits SHALL be separated by at least one IDLE cycle; req=0 for at least 1 cycle between flits.
REQ-024 FIFO order SHALL be preserved; no flit is dropped or duplicated.
REQ-025 busy=1 in the same cycle as a pop SHALL still reject ena; this is conservative by design.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear: state=IDLE, req=0, data_out=0, count=0, head=0, tail=0, synchronizer flops=0.
REQ-027 Reset asserted mid-handshake SHALL drop req immediately and discard buffered flits; recovery of the neighbour handshake is a system-level concern.
REQ-028 FIFO storage SHALL NOT require reset.

Structure
REQ-029 SIZE and the direction constants SHALL stay in the shared constants include; no new global macros are added.
REQ-030 FSM state encodings SHALL be localparams inside tx_link.
REQ-031 The synchronizer SHALL be a separate sub-module, sync2 (1-bit, clk, reset_n, d, q), reusable by the receive side.

Verification
REQ-032 Reset: hold reset_n=0 with ack=0 -> req=0, busy=0, data_out=0; after release, 10 idle cycles with req=0.
REQ-033 Single flit: ena=1 with item_in=8'h3A for 1 cycle -> req=1 on the next edge with data_out=8'h3A; raise ack -> req falls 2-3 cycles later; drop ack -> return to IDLE.
REQ-034 Fill: ena=1 for 3 consecutive cycles with 8'h01, 8'h02, 8'h03 and ack held 0 -> busy=1 after the second write; third write ignored; link emits 01 then 02 only.
REQ-035 Simultaneous: count=2 and a pop edge coincides with a new ena after busy drops -> count stays consistent; order 01, 02, 04 observed on data_out.
REQ-036 Mid-transfer reset: reset_n=0 while req=1 -> req=0 asynchronously; after release, count=0 and no spurious req.
REQ-037 Random stress: 1000 flits with random ena and random ack delay of 0-7 cycles -> scoreboard sees in-order, loss-free delivery and data_out never changes while req=1.
